// File: rtl/mc_pkg.sv
// mc_pkg: definitions shared by the multi-cycle sequencer and the RV32I decoder.
//   - state_t   : sequencer state encoding (3 bits, also visible on state_dbg)
//   - OP_*      : opcode[6:2] major-opcode values of the supported subset
//   - BR_*      : decoder Branch codes (000 = not a branch)
//   - opcode_legal() : true when a 7-bit opcode belongs to the supported subset
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_ITYPE  = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BLTU = 3'b011;
  localparam logic [2:0] BR_JAL  = 3'b100;
  localparam logic [2:0] BR_JALR = 3'b101;

  // Legal = 32-bit encoding (low bits 11) and a major opcode we implement.
  function automatic logic opcode_legal(input logic [6:0] op);
    logic v_legal;
    v_legal = 1'b0;
    if (op[1:0] == 2'b11) begin
      case (op[6:2])
        OP_LUI, OP_AUIPC, OP_RTYPE, OP_ITYPE, OP_LOAD,
        OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: v_legal = 1'b1;
        default:                              v_legal = 1'b0;
      endcase
    end else begin
      v_legal = 1'b0;
    end
    return v_legal;
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters: cycle and retired-instruction counters for mc_sequencer.
// Only instantiated when PERF_COUNTERS_EN is defined.
// Ports:
//   clk, rstn      clock, async active-low reset
//   busy           sequencer is executing (counts cycles)
//   pc_we          one pulse per retired instruction
//   cycle_cnt      busy cycles, wraps modulo 2^32
//   instret_cnt    retired instructions, wraps modulo 2^32
module mc_perf_counters (
  input  logic        clk,
  input  logic        rstn,
  input  logic        busy,
  input  logic        pc_we,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  // Busy-cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle_cnt <= 32'd0;
    end else if (busy) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  // Retired-instruction counter: every instruction ends with exactly one pc_we.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instret_cnt <= 32'd0;
    end else if (pc_we) begin
      r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the RV32I-subset datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, pulsing the
// datapath register enables and running req/ack handshakes to imem/dmem.
// Illegal opcodes trap into a sticky HALT state (left only by reset).
//
// Optional feature macro: PERF_COUNTERS_EN adds cycle_cnt/instret_cnt outputs.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   run                1 = execute, 0 = stop at next instruction boundary
//   opcode             IR[6:0]
//   mem_read/mem_write/reg_write/branch   decoder outputs
//   imem_ack, dmem_ack memory handshake acknowledges
//   imem_req, dmem_req, dmem_we           memory requests (Moore)
//   ir_we, opnd_we, aluout_we, mdr_we, rf_we, pc_we   single-cycle strobes
//   busy, halted, state_dbg               status
//   cycle_cnt, instret_cnt                (PERF_COUNTERS_EN only)
module mc_sequencer
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [2:0]  branch,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        opnd_we,
  output logic        aluout_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        busy,
  output logic        halted,
`ifdef PERF_COUNTERS_EN
  output logic [2:0]  state_dbg,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`else
  output logic [2:0]  state_dbg
`endif
);

  state_t r_state;
  state_t w_next_state;
  state_t w_boundary_state;

  // Branch direction is resolved in the datapath (it selects PC+4 or target);
  // the sequencer only needs to know the instruction neither accesses memory
  // nor writes rd, so the code itself is not decoded here.
  logic w_unused_branch;
  assign w_unused_branch = |branch;

  // run is only looked at when an instruction retires.
  assign w_boundary_state = run ? ST_FETCH : ST_IDLE;

  // State register; async reset drops any pending request immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and strobe/request decode.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_we        = 1'b0;
    opnd_we      = 1'b0;
    aluout_we    = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we        = 1'b1;
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode_legal(opcode)) begin
          opnd_we      = 1'b1;
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_HALT;
        end
      end
      ST_EXEC: begin
        aluout_we = 1'b1;
        if (mem_read || mem_write) begin
          w_next_state = ST_MEM;
        end else if (reg_write) begin
          w_next_state = ST_WB;
        end else begin
          // Conditional branch retires here.
          pc_we        = 1'b1;
          w_next_state = w_boundary_state;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        if (dmem_ack) begin
          if (mem_read) begin
            mdr_we       = 1'b1;
            w_next_state = ST_WB;
          end else begin
            // Store retires on its ack.
            pc_we        = 1'b1;
            w_next_state = w_boundary_state;
          end
        end else begin
          w_next_state = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we        = 1'b1;
        pc_we        = 1'b1;
        w_next_state = w_boundary_state;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        // Unreachable encoding: park safely in IDLE with everything off.
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted    = (r_state == ST_HALT);
  assign state_dbg = r_state;

`ifdef PERF_COUNTERS_EN
  mc_perf_counters u_perf_counters (
    .clk         (clk),
    .rstn        (rstn),
    .busy        (busy),
    .pc_we       (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: table of single instructions with
// hand-computed cycle counts, state traces (one octal digit per cycle) and
// strobe counts, followed by hand-written HALT, reset and counter sequences.
module tb_mc_sequencer;

  logic        clk;
  logic        rstn;
  logic        run;
  logic [6:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [2:0]  branch;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        opnd_we;
  logic        aluout_we;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic        busy;
  logic        halted;
  logic [2:0]  state_dbg;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int n_checks;
  int n_fail;

  mc_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run),
    .opcode    (opcode),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .branch    (branch),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .ir_we     (ir_we),
    .opnd_we   (opnd_we),
    .aluout_we (aluout_we),
    .mdr_we    (mdr_we),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .busy      (busy),
    .halted    (halted),
`ifdef PERF_COUNTERS_EN
    .state_dbg   (state_dbg),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`else
    .state_dbg (state_dbg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [2:0]  br;
    int          iw;       // imem wait cycles before ack
    int          dw;       // dmem wait cycles before ack
    int          drop_at;  // cycle number after which run goes 0 (0 = never)
    int          e_cyc;
    logic [29:0] e_trace;
    int          e_rf;
    int          e_mdr;
    int          e_dreq;
    int          e_dwe;
    logic [2:0]  e_next;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] all_out();
    return {imem_req, dmem_req, dmem_we, ir_we, opnd_we, aluout_we,
            mdr_we, rf_we, pc_we, busy, halted};
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns at the
  // negedge after its pc_we cycle.
  task automatic run_instr(input vec_t v, input int idx);
    int cyc, rfc, mdrc, dreqc, dwec, irc, aluc, iw, dw;
    logic [29:0] tr;
    bit done;
    cyc = 0; rfc = 0; mdrc = 0; dreqc = 0; dwec = 0; irc = 0; aluc = 0;
    iw = 0; dw = 0; tr = 30'd0; done = 1'b0;
    check($sformatf("v%0d_start_fetch", idx), {29'd0, state_dbg}, 32'd1);
    opcode    = v.op;
    mem_read  = v.mr;
    mem_write = v.mw;
    reg_write = v.rw;
    branch    = v.br;
    while (!done && cyc < 40) begin
      imem_ack = imem_req && (iw == v.iw);
      dmem_ack = dmem_req && (dw == v.dw);
      if (imem_req) iw++;
      if (dmem_req) dw++;
      #1;
      cyc++;
      tr = {tr[26:0], state_dbg};
      if (rf_we) rfc++;
      if (mdr_we) mdrc++;
      if (ir_we) irc++;
      if (aluout_we) aluc++;
      if (dmem_req) dreqc++;
      if (dmem_req && dmem_we) dwec++;
      if (pc_we) done = 1'b1;
      if (cyc == v.drop_at) run = 1'b0;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) check($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    check($sformatf("v%0d_cycles", idx), cyc, v.e_cyc);
    check($sformatf("v%0d_trace", idx), {2'd0, tr}, {2'd0, v.e_trace});
    check($sformatf("v%0d_rf_we", idx), rfc, v.e_rf);
    check($sformatf("v%0d_mdr_we", idx), mdrc, v.e_mdr);
    check($sformatf("v%0d_dmem_req", idx), dreqc, v.e_dreq);
    check($sformatf("v%0d_dmem_we", idx), dwec, v.e_dwe);
    check($sformatf("v%0d_ir_we", idx), irc, 32'd1);
    check($sformatf("v%0d_aluout_we", idx), aluc, 32'd1);
    check($sformatf("v%0d_next_state", idx), {29'd0, state_dbg}, {29'd0, v.e_next});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vec_t va;
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b0; run = 1'b0; opcode = 7'h13;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; branch = 3'd0;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    //          op     mr    mw    rw    br   iw dw drop cyc trace          rf mdr dreq dwe next
    tbl[0]  = '{7'h33, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0, 0, 4, 30'o1235,      1, 0, 0, 0, 3'd1}; // add
    tbl[1]  = '{7'h33, 1'b0, 1'b0, 1'b1, 3'd0, 2, 0, 0, 6, 30'o111235,    1, 0, 0, 0, 3'd1}; // add, slow fetch
    tbl[2]  = '{7'h03, 1'b1, 1'b0, 1'b1, 3'd0, 0, 3, 0, 8, 30'o12344445,  1, 1, 4, 0, 3'd1}; // lw, 3 waits
    tbl[3]  = '{7'h23, 1'b0, 1'b1, 1'b0, 3'd0, 0, 0, 0, 4, 30'o1234,      0, 0, 1, 1, 3'd1}; // sw
    tbl[4]  = '{7'h63, 1'b0, 1'b0, 1'b0, 3'd1, 0, 0, 0, 3, 30'o123,       0, 0, 0, 0, 3'd1}; // beq
    tbl[5]  = '{7'h03, 1'b1, 1'b0, 1'b1, 3'd0, 0, 3, 5, 8, 30'o12344445,  1, 1, 4, 0, 3'd0}; // lw, run dropped in MEM
    tbl[6]  = '{7'h03, 1'b1, 1'b0, 1'b1, 3'd0, 0, 0, 0, 5, 30'o12345,     1, 1, 1, 0, 3'd1}; // lw zero wait
    tbl[7]  = '{7'h23, 1'b0, 1'b1, 1'b0, 3'd0, 0, 2, 0, 6, 30'o123444,    0, 0, 3, 3, 3'd1}; // sw, 2 waits
    tbl[8]  = '{7'h6F, 1'b0, 1'b0, 1'b1, 3'd4, 0, 0, 0, 4, 30'o1235,      1, 0, 0, 0, 3'd1}; // jal
    tbl[9]  = '{7'h37, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0, 0, 4, 30'o1235,      1, 0, 0, 0, 3'd1}; // lui
    tbl[10] = '{7'h13, 1'b0, 1'b0, 1'b1, 3'd0, 1, 0, 0, 5, 30'o11235,     1, 0, 0, 0, 3'd1}; // addi
    tbl[11] = '{7'h63, 1'b0, 1'b0, 1'b0, 3'd2, 1, 0, 0, 4, 30'o1123,      0, 0, 0, 0, 3'd1}; // blt
    tbl[12] = '{7'h67, 1'b0, 1'b0, 1'b1, 3'd5, 0, 0, 0, 4, 30'o1235,      1, 0, 0, 0, 3'd1}; // jalr
    tbl[13] = '{7'h17, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0, 0, 4, 30'o1235,      1, 0, 0, 0, 3'd1}; // auipc

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {21'd0, all_out()}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);

    run  = 1'b1;
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i], i);
      if (!run) begin
        // Stopped at the boundary; stray acks must be ignored while idle.
        check($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_idle_stray_ack", i), {18'd0, all_out(), state_dbg}, 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_resume_fetch", i), {29'd0, state_dbg}, 32'd1);
      end
    end

    // Illegal opcode 0x7F traps into HALT and stays there.
    opcode = 7'h7F; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; branch = 3'd0;
    imem_ack = 1'b1;
    @(negedge clk);
    check("halt_decode_state", {29'd0, state_dbg}, 32'd2);
    check("halt_decode_no_opnd_we", {31'd0, opnd_we}, 32'd0);
    @(negedge clk);
    check("halt_state", {29'd0, state_dbg}, 32'd6);
    check("halt_flags", {30'd0, halted, busy}, 32'd2);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if ({imem_req, dmem_req, dmem_we, ir_we, opnd_we, aluout_we, mdr_we, rf_we, pc_we} != 9'd0) cnt++;
    end
    check("halt_quiet_100", cnt, 32'd0);
    check("halt_sticky", {29'd0, state_dbg}, 32'd6);

    // Reset asserted mid-fetch with no ack: request drops without a clock edge.
    imem_ack = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_mid_fetch_pre", {30'd0, state_dbg[0], imem_req}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_async_state", {29'd0, state_dbg}, 32'd0);
    check("rst_async_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Opcode with legal major bits but low bits != 11 also halts.
    opcode = 7'h31;
    imem_ack = 1'b1;
    @(negedge clk);
    check("lowbits_fetch", {29'd0, state_dbg}, 32'd1);
    @(negedge clk);
    check("lowbits_decode", {29'd0, state_dbg}, 32'd2);
    @(negedge clk);
    check("lowbits_halt", {29'd0, state_dbg}, 32'd6);
    imem_ack = 1'b0;

`ifdef PERF_COUNTERS_EN
    rstn = 1'b0;
    @(negedge clk);
    check("perf_reset_cycle", cycle_cnt, 32'd0);
    check("perf_reset_instret", instret_cnt, 32'd0);
    rstn = 1'b1;
    run  = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      va = tbl[0];
      va.drop_at = (k == 9) ? 1 : 0;
      va.e_next  = (k == 9) ? 3'd0 : 3'd1;
      run_instr(va, 100 + k);
    end
    check("perf_instret_10", instret_cnt, 32'd10);
    check("perf_cycle_40", cycle_cnt, 32'd40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the RV32I subset datapath (lui, auipc, R-type add/sub/xor/or/and, addi/slli/srli/srai, lw, sw, beq/blt/bltu, jal, jalr). It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. At each step it pulses the datapath register write-enables and runs req/ack handshakes to instruction and data memory. It consumes the combinational decoder's MemRead/MemWrite/RegWrite/Branch outputs plus the raw opcode, and sits between the decoder and the datapath register enables.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  7  instruction register bits [6:0]
- mem_read  in  1  decoder MemRead
- mem_write  in  1  decoder MemWrite
- reg_write  in  1  decoder RegWrite
- branch  in  3  decoder Branch code (000 = none)
- imem_ack  in  1  instruction memory: read data valid this cycle
- dmem_ack  in  1  data memory: access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a write
- ir_we  out  1  load IR from imem data
- opnd_we  out  1  latch rs1/rs2/imm operand registers
- aluout_we  out  1  latch ALU result
- mdr_we  out  1  latch dmem read data
- rf_we  out  1  register file write of rd
- pc_we  out  1  PC update; datapath selects PC+4 or branch/jump target
- busy  out  1  1 in any state except IDLE and HALT
- halted  out  1  illegal opcode trapped
- state_dbg  out  3  current state encoding

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: imem_req=1. When imem_ack=1, pulse ir_we and go to DECODE. Otherwise stay.
- DECODE:
  - If opcode[6:2] is not one of 01101, 00101, 01100, 00100, 00000, 01000, 11000, 11011, 11001, or opcode[1:0]≠11, go to HALT.
  - Otherwise pulse opnd_we and go to EXEC.
- EXEC: pulse aluout_we, then take the first matching rule:
  - mem_read or mem_write → MEM.
  - reg_write → WB.
  - otherwise (conditional branch) → pulse pc_we, go to FETCH.
- MEM:
  - Outputs: dmem_req=1, dmem_we=mem_write.
  - On dmem_ack with mem_read: pulse mdr_we, go to WB.
  - On dmem_ack with a store: pulse pc_we, go to FETCH.
- WB: pulse rf_we and pc_we, then go to FETCH.
- Instruction boundary (end of WB, end of EXEC for a branch, end of MEM for a store):
  - run=0 → IDLE instead of FETCH.
  - run changes mid-instruction are ignored until the boundary.
- HALT: sticky until reset. halted=1, all strobes 0, no memory requests.
- Decoder inputs are sampled only in DECODE, EXEC and MEM. IR is stable from DECODE until the next ir_we.

## Timing
- Reset: state=IDLE. All outputs 0 (state_dbg=0, halted=0). Reset is honoured immediately in any state, including mid-handshake; the pending req drops asynchronously.
- Strobes (ir_we, opnd_we, aluout_we, mdr_we, rf_we, pc_we) are single-cycle and combinational from state plus ack.
- imem_req and dmem_req are Moore outputs of FETCH and MEM. Each is held until its ack, and drops the cycle after the ack.
- An ack arriving without a matching req is ignored. Ack may arrive in the same cycle req rises (zero-wait memory).
- Cycles per instruction, zero-wait memory: branch 3; R/I-type, lui, auipc, jal, jalr 4; sw 4; lw 5. Each wait cycle on ack adds 1.
- The instruction's pc_we falls in its final cycle. The datapath's PC+4 and target must be valid then.

## Configuration
- PERF_COUNTERS_EN defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every clk while busy=1.
  - instret_cnt increments on each pc_we pulse.
  - Both wrap modulo 2^32.
- Undefined: the two ports and the counters are absent. All other behaviour is identical.

## Structure
- Shared package mc_pkg holds:
  - state enum (3-bit, encodings above)
  - opcode[6:2] constants (OP_LUI, OP_AUIPC, OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR)
  - Branch code constants
- The decoder uses the same package.
- Optional sub-module mc_perf_counters holds the two counters, instantiated only under PERF_COUNTERS_EN. The FSM stays in mc_sequencer.

## Test plan
- Reset, then run=1 with imem_ack tied 1 and an add instruction: states go 1,2,3,5 and repeat. rf_we and pc_we are both high in cycle 4 only.
- lw with dmem_ack delayed 3 cycles: dmem_req is high for 4 cycles with dmem_we=0. mdr_we pulses on the ack cycle. Total 8 cycles, ending with rf_we+pc_we.
- sw with zero wait: dmem_req=1 and dmem_we=1 for exactly 1 cycle, with pc_we in the same cycle. rf_we never asserts. 4 cycles total.
- beq: pc_we in the EXEC cycle, 3 cycles total. Then opcode 0x7F: HALT, halted=1, no further imem_req for 100 cycles with run=1.
- run dropped during the MEM wait of lw: the instruction completes through WB, then IDLE, busy=0. Reasserting run resumes at FETCH.
- rstn pulsed low while imem_req=1 and no ack: imem_req drops without waiting for a clock edge, state_dbg=0. With PERF_COUNTERS_EN, both counters read 0 and, after 10 zero-wait add instructions, instret_cnt=10 and cycle_cnt=40.
